// File: rtl/tl_xbar_pkg.sv
// Shared TileLink-UL constants, beat-count helper and error-responder states
// for the 1:N crossbar family.
package tl_xbar_pkg;

  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ERR_IDLE,
    ERR_SINK,
    ERR_RESP
  } err_state_e;

  // Beats in a message: bursts only exist for data-carrying messages wider than one beat.
  function automatic int unsigned num_beats(input int unsigned size, input logic has_data,
                                            input int unsigned lg_beat);
    if (has_data && size > lg_beat) return 32'd1 << (size - lg_beat);
    return 32'd1;
  endfunction

endpackage

// File: rtl/tl_rr_lock_arbiter.sv
// Round-robin arbiter that holds its grant for the remaining beats of a burst.
// Requester index order doubles as the wrap-around priority order.
module tl_rr_lock_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     valid,
  input  logic             take,
  input  logic [CNT_W-1:0] beats_m1,
  output logic [N-1:0]     grant,
  output logic [N-1:0]     ready
);

  logic [N-1:0]     rr_mask;
  logic [N-1:0]     lock_state;
  logic [N-1:0]     winner;
  logic [N-1:0]     masked;
  logic [CNT_W-1:0] beats_left;
  logic             locked;
  logic             fire;
  logic             found;

  assign locked = (beats_left != '0);
  assign masked = valid & rr_mask;

  // rr_mask holds the indices above the last winner; fall back to plain lowest-valid.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && valid[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign grant = locked ? lock_state : winner;
  assign ready = {N{take}} & grant;
  assign fire  = take & |(valid & grant);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beats_left <= '0;
      rr_mask    <= '1;
      lock_state <= '0;
    end else if (locked) begin
      if (fire) beats_left <= beats_left - 1'b1;
    end else if (take) begin
      lock_state <= winner;
      beats_left <= |(valid & winner) ? beats_m1 : '0;
      if (|valid) rr_mask <= ~((winner << 1) - N'(1));
    end
  end

  a_winner_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(winner));
  a_valid_wins:    assert property (@(posedge clock) disable iff (reset) |valid |-> |winner);
  a_lock_valid:    assert property (@(posedge clock) disable iff (reset)
                                    locked |-> |(valid & lock_state));

endmodule

// File: rtl/tl_xbar_1to_n.sv
// 1-master / N_OUT-slave TileLink-UL crossbar: address-decoded A routing,
// burst-locked round-robin D return, and a denied-response sink for unmapped addresses.
module tl_xbar_1to_n
  import tl_xbar_pkg::*;
#(
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SIZE_W = 3,
  parameter int unsigned SRC_W  = 1,
  parameter logic [N_OUT*ADDR_W-1:0] BASE = {9'h100, 9'h000},
  parameter logic [N_OUT*ADDR_W-1:0] MASK = {9'h0FF, 9'h0FF}
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      auto_in_a_valid,
  output logic                      auto_in_a_ready,
  input  logic [2:0]                auto_in_a_bits_opcode,
  input  logic [SIZE_W-1:0]         auto_in_a_bits_size,
  input  logic [SRC_W-1:0]          auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]         auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0]       auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]         auto_in_a_bits_data,
  output logic                      auto_in_d_valid,
  input  logic                      auto_in_d_ready,
  output logic [2:0]                auto_in_d_bits_opcode,
  output logic [1:0]                auto_in_d_bits_param,
  output logic [SIZE_W-1:0]         auto_in_d_bits_size,
  output logic [SRC_W-1:0]          auto_in_d_bits_source,
  output logic                      auto_in_d_bits_sink,
  output logic                      auto_in_d_bits_denied,
  output logic [DATA_W-1:0]         auto_in_d_bits_data,
  output logic                      auto_in_d_bits_corrupt,
  output logic [N_OUT-1:0]          auto_out_a_valid,
  input  logic [N_OUT-1:0]          auto_out_a_ready,
  output logic [N_OUT*3-1:0]        auto_out_a_bits_opcode,
  output logic [N_OUT*SIZE_W-1:0]   auto_out_a_bits_size,
  output logic [N_OUT*SRC_W-1:0]    auto_out_a_bits_source,
  output logic [N_OUT*ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [N_OUT*DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [N_OUT*DATA_W-1:0]   auto_out_a_bits_data,
  input  logic [N_OUT-1:0]          auto_out_d_valid,
  output logic [N_OUT-1:0]          auto_out_d_ready,
  input  logic [N_OUT*3-1:0]        auto_out_d_bits_opcode,
  input  logic [N_OUT*2-1:0]        auto_out_d_bits_param,
  input  logic [N_OUT*SIZE_W-1:0]   auto_out_d_bits_size,
  input  logic [N_OUT*SRC_W-1:0]    auto_out_d_bits_source,
  input  logic [N_OUT-1:0]          auto_out_d_bits_sink,
  input  logic [N_OUT-1:0]          auto_out_d_bits_denied,
  input  logic [N_OUT*DATA_W-1:0]   auto_out_d_bits_data,
  input  logic [N_OUT-1:0]          auto_out_d_bits_corrupt
);

  localparam int unsigned LG_BEAT = $clog2(DATA_W / 8);
  localparam int unsigned MAX_LG  = (1 << SIZE_W) - 1;
  localparam int unsigned CNT_W   = (MAX_LG > LG_BEAT) ? MAX_LG - LG_BEAT : 1;
  localparam int unsigned NR      = N_OUT + 1;

  logic [N_OUT-1:0]  hit;
  logic              unmapped;
  logic              err_a_ready;
  logic              err_d_valid;
  logic              err_a_fire;
  logic              err_d_fire;
  logic              a_has_data;
  logic [CNT_W-1:0]  a_beats_m1;
  logic [CNT_W-1:0]  d_beats_m1;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     grant_ready;

  err_state_e        err_state, err_state_n;
  logic [CNT_W-1:0]  err_cnt, err_cnt_n;
  logic              err_get, err_get_n;
  logic [SIZE_W-1:0] err_size, err_size_n;
  logic [SRC_W-1:0]  err_src, err_src_n;

  for (genvar i = 0; i < N_OUT; i++) begin : g_port
    localparam logic [ADDR_W-1:0] B = BASE[i*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] M = MASK[i*ADDR_W +: ADDR_W];
    assign hit[i] = ((auto_in_a_bits_address ^ B) & ~M) == '0;
    assign auto_out_a_bits_address[i*ADDR_W +: ADDR_W] = auto_in_a_bits_address & M;
    for (genvar j = i + 1; j < N_OUT; j++) begin : g_chk
      if (((B ^ BASE[j*ADDR_W +: ADDR_W]) & ~M & ~MASK[j*ADDR_W +: ADDR_W]) == '0) begin : g_overlap
        $error("tl_xbar_1to_n: address regions %0d and %0d overlap", i, j);
      end
    end
  end

  assign unmapped               = ~|hit;
  assign auto_out_a_valid       = {N_OUT{auto_in_a_valid}} & hit;
  assign auto_out_a_bits_opcode = {N_OUT{auto_in_a_bits_opcode}};
  assign auto_out_a_bits_size   = {N_OUT{auto_in_a_bits_size}};
  assign auto_out_a_bits_source = {N_OUT{auto_in_a_bits_source}};
  assign auto_out_a_bits_mask   = {N_OUT{auto_in_a_bits_mask}};
  assign auto_out_a_bits_data   = {N_OUT{auto_in_a_bits_data}};
  assign auto_in_a_ready        = |(hit & auto_out_a_ready) | (unmapped & err_a_ready);

  assign err_a_ready = (err_state != ERR_RESP);
  assign err_d_valid = (err_state == ERR_RESP);
  assign err_a_fire  = auto_in_a_valid & unmapped & err_a_ready;
  assign err_d_fire  = err_d_valid & grant_ready[N_OUT];
  assign a_has_data  = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                       (auto_in_a_bits_opcode == OP_PUT_PARTIAL);
  assign a_beats_m1  = CNT_W'(num_beats(32'(auto_in_a_bits_size), 1'b1, LG_BEAT) - 1);

  // err_cnt counts remaining A beats in SINK, then remaining D beats in RESP.
  always_comb begin
    err_state_n = err_state;
    err_cnt_n   = err_cnt;
    err_get_n   = err_get;
    err_size_n  = err_size;
    err_src_n   = err_src;
    case (err_state)
      ERR_IDLE: if (err_a_fire) begin
        err_get_n  = (auto_in_a_bits_opcode == OP_GET);
        err_size_n = auto_in_a_bits_size;
        err_src_n  = auto_in_a_bits_source;
        if (a_has_data && a_beats_m1 != '0) begin
          err_state_n = ERR_SINK;
          err_cnt_n   = a_beats_m1;
        end else begin
          err_state_n = ERR_RESP;
          err_cnt_n   = a_has_data ? '0 : (err_get_n ? a_beats_m1 : '0);
        end
      end
      ERR_SINK: if (err_a_fire) begin
        if (err_cnt == CNT_W'(1)) begin
          err_state_n = ERR_RESP;
          err_cnt_n   = '0;
        end else begin
          err_cnt_n = err_cnt - 1'b1;
        end
      end
      ERR_RESP: if (err_d_fire) begin
        if (err_cnt == '0) err_state_n = ERR_IDLE;
        else               err_cnt_n   = err_cnt - 1'b1;
      end
      default: err_state_n = ERR_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_state <= ERR_IDLE;
      err_cnt   <= '0;
      err_get   <= 1'b0;
      err_size  <= '0;
      err_src   <= '0;
    end else begin
      err_state <= err_state_n;
      err_cnt   <= err_cnt_n;
      err_get   <= err_get_n;
      err_size  <= err_size_n;
      err_src   <= err_src_n;
    end
  end

  assign req_valid = {err_d_valid, auto_out_d_valid};

  tl_rr_lock_arbiter #(.N(NR), .CNT_W(CNT_W)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .valid    (req_valid),
    .take     (auto_in_d_ready),
    .beats_m1 (d_beats_m1),
    .grant    (grant),
    .ready    (grant_ready)
  );

  assign auto_out_d_ready = grant_ready[N_OUT-1:0];
  assign auto_in_d_valid  = |(req_valid & grant);
  assign d_beats_m1 = CNT_W'(num_beats(32'(auto_in_d_bits_size), auto_in_d_bits_opcode[0], LG_BEAT) - 1);

  always_comb begin
    auto_in_d_bits_opcode  = '0;
    auto_in_d_bits_param   = '0;
    auto_in_d_bits_size    = '0;
    auto_in_d_bits_source  = '0;
    auto_in_d_bits_sink    = 1'b0;
    auto_in_d_bits_denied  = 1'b0;
    auto_in_d_bits_data    = '0;
    auto_in_d_bits_corrupt = 1'b0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (grant[i]) begin
        auto_in_d_bits_opcode  = auto_out_d_bits_opcode[i*3 +: 3];
        auto_in_d_bits_param   = auto_out_d_bits_param[i*2 +: 2];
        auto_in_d_bits_size    = auto_out_d_bits_size[i*SIZE_W +: SIZE_W];
        auto_in_d_bits_source  = auto_out_d_bits_source[i*SRC_W +: SRC_W];
        auto_in_d_bits_sink    = auto_out_d_bits_sink[i];
        auto_in_d_bits_denied  = auto_out_d_bits_denied[i];
        auto_in_d_bits_data    = auto_out_d_bits_data[i*DATA_W +: DATA_W];
        auto_in_d_bits_corrupt = auto_out_d_bits_corrupt[i];
      end
    end
    if (grant[N_OUT]) begin
      auto_in_d_bits_opcode  = err_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
      auto_in_d_bits_size    = err_size;
      auto_in_d_bits_source  = err_src;
      auto_in_d_bits_denied  = 1'b1;
      auto_in_d_bits_corrupt = err_get;
    end
  end

endmodule
